// File: rtl/wino_pkg.sv
// Shared Winograd tile types: element, row and 6x6 tile layouts used by the
// input tile server and the data controller.
package wino_pkg;

  localparam int unsigned TILE_N = 6;
  localparam int unsigned DATA_W = 16;

  typedef logic signed [DATA_W-1:0] elem_t;
  typedef elem_t [TILE_N-1:0]       row_t;   // row_t[col]
  typedef row_t  [TILE_N-1:0]       tile_t;  // tile_t[row][col]

endpackage

// File: rtl/input_tile_server_if.sv
// Read request/response bus between the data controller (master) and the
// input tile server (slave).
interface input_tile_server_if;

  logic                input_request_i;
  logic [7:0]          input_addr_i_1;
  logic [7:0]          input_addr_i_2;
  wino_pkg::tile_t     input_data_o_1;
  wino_pkg::tile_t     input_data_o_2;
  logic                input_valid_o;
  logic                miss_o;

  modport master (
    output input_request_i, input_addr_i_1, input_addr_i_2,
    input  input_data_o_1, input_data_o_2, input_valid_o, miss_o
  );

  modport slave (
    input  input_request_i, input_addr_i_1, input_addr_i_2,
    output input_data_o_1, input_data_o_2, input_valid_o, miss_o
  );

endinterface

// File: rtl/input_tile_server_tile_store.sv
// Tile storage: one row-wide write port, two combinational whole-tile read
// ports. Contents are deliberately not reset; the owner's valid bitmap
// decides what is visible.
module tile_store
  import wino_pkg::*;
#(
  parameter int unsigned TILE_DEPTH = 64,
  parameter int unsigned AW         = 6
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [2:0]    wr_row,
  input  row_t          wr_data,
  input  logic [AW-1:0] rd_addr_1,
  input  logic [AW-1:0] rd_addr_2,
  output tile_t         rd_tile_1,
  output tile_t         rd_tile_2
);

  tile_t mem [TILE_DEPTH];

  // Row write; caller guarantees address and row are in range
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr][wr_row] <= wr_data;
  end

  assign rd_tile_1 = mem[rd_addr_1];
  assign rd_tile_2 = mem[rd_addr_2];

endmodule

// File: rtl/input_tile_server.sv
// Input tile server: stores TILE_DEPTH 6x6 tiles loaded row by row and serves
// pairs of tiles with a fixed 2-cycle read latency.
// Optional: define INPUT_TILE_SERVER_WR_FWD_EN to forward a same-cycle row
// write (and its row-5 valid) into the read being sampled.
module input_tile_server
  import wino_pkg::*;
#(
  parameter int unsigned TILE_DEPTH = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      wr_en_i,
  input  logic [7:0]                wr_tile_addr_i,
  input  logic [2:0]                wr_row_i,
  input  row_t                      wr_data_i,
  input  logic                      clear_i,
  input_tile_server_if.slave        rd,
  output logic [8:0]                tiles_loaded_o
);

  localparam int unsigned AW     = (TILE_DEPTH > 1) ? $clog2(TILE_DEPTH) : 1;
  localparam logic [8:0]  DEPTH9 = 9'(TILE_DEPTH);

  logic [TILE_DEPTH-1:0] valid_q;
  logic [8:0]            loaded_q;

  logic                  wr_ok;
  logic                  wr_last;
  logic [AW-1:0]         wr_idx;
  logic [AW-1:0]         rd_idx_1;
  logic [AW-1:0]         rd_idx_2;
  logic                  rd_rng_1;
  logic                  rd_rng_2;
  tile_t                 st_tile_1;
  tile_t                 st_tile_2;
  tile_t                 smp_tile_1;
  tile_t                 smp_tile_2;
  logic                  smp_vld_1;
  logic                  smp_vld_2;
  logic                  smp_hit;

  logic                  s1_req, s1_hit;
  tile_t                 s1_tile_1, s1_tile_2;
  logic                  s2_req, s2_hit;
  tile_t                 s2_tile_1, s2_tile_2;
  logic                  out_valid_q, out_miss_q;
  tile_t                 out_tile_1_q, out_tile_2_q;

  assign wr_ok    = wr_en_i && (wr_row_i <= 3'd5) && ({1'b0, wr_tile_addr_i} < DEPTH9);
  assign wr_last  = (wr_row_i == 3'd5);
  assign wr_idx   = wr_tile_addr_i[AW-1:0];
  assign rd_idx_1 = rd.input_addr_i_1[AW-1:0];
  assign rd_idx_2 = rd.input_addr_i_2[AW-1:0];
  assign rd_rng_1 = ({1'b0, rd.input_addr_i_1} < DEPTH9);
  assign rd_rng_2 = ({1'b0, rd.input_addr_i_2} < DEPTH9);

  tile_store #(
    .TILE_DEPTH (TILE_DEPTH),
    .AW         (AW)
  ) u_store (
    .clk        (clk),
    .wr_en      (wr_ok),
    .wr_addr    (wr_idx),
    .wr_row     (wr_row_i),
    .wr_data    (wr_data_i),
    .rd_addr_1  (rd_idx_1),
    .rd_addr_2  (rd_idx_2),
    .rd_tile_1  (st_tile_1),
    .rd_tile_2  (st_tile_2)
  );

  // Valid bitmap: clear beats writes; row 5 completes a tile, earlier rows mark it reloading
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      valid_q <= '0;
    else if (clear_i)  valid_q <= '0;
    else if (wr_ok)    valid_q[wr_idx] <= wr_last;
  end

  // Loaded counter tracks valid-bit transitions in the same edge as the bitmap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      loaded_q <= '0;
    else if (clear_i)  loaded_q <= '0;
    else if (wr_ok) begin
      if (!valid_q[wr_idx] && wr_last && (loaded_q != DEPTH9))
        loaded_q <= loaded_q + 9'd1;
      else if (valid_q[wr_idx] && !wr_last && (loaded_q != 9'd0))
        loaded_q <= loaded_q - 9'd1;
    end
  end

  assign tiles_loaded_o = loaded_q;

  // Snapshot of tile contents and validity as seen by a request at this edge
  always_comb begin
    smp_tile_1 = st_tile_1;
    smp_tile_2 = st_tile_2;
    smp_vld_1  = valid_q[rd_idx_1];
    smp_vld_2  = valid_q[rd_idx_2];
`ifdef INPUT_TILE_SERVER_WR_FWD_EN
    // Forwarded validity is the post-write state, still subject to clear priority
    if (wr_ok && (wr_idx == rd_idx_1)) begin
      smp_tile_1[wr_row_i] = wr_data_i;
      smp_vld_1            = wr_last && !clear_i;
    end
    if (wr_ok && (wr_idx == rd_idx_2)) begin
      smp_tile_2[wr_row_i] = wr_data_i;
      smp_vld_2            = wr_last && !clear_i;
    end
`endif
    smp_hit = rd_rng_1 && rd_rng_2 && smp_vld_1 && smp_vld_2;
  end

  // Pipeline control bits; reset empties the pipe so nothing emerges afterwards
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_req <= 1'b0;
      s1_hit <= 1'b0;
      s2_req <= 1'b0;
      s2_hit <= 1'b0;
    end else begin
      s1_req <= rd.input_request_i;
      s1_hit <= smp_hit;
      s2_req <= s1_req;
      s2_hit <= s1_hit;
    end
  end

  // Pipeline data captured at sample time so later writes cannot alter a response
  always_ff @(posedge clk) begin
    if (rd.input_request_i) begin
      s1_tile_1 <= smp_tile_1;
      s1_tile_2 <= smp_tile_2;
    end
    if (s1_req) begin
      s2_tile_1 <= s1_tile_1;
      s2_tile_2 <= s1_tile_2;
    end
  end

  // Response stage: hit returns tiles, miss zeroes data, idle holds data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      out_miss_q   <= 1'b0;
      out_tile_1_q <= '0;
      out_tile_2_q <= '0;
    end else if (s2_req) begin
      out_valid_q  <= s2_hit;
      out_miss_q   <= !s2_hit;
      out_tile_1_q <= s2_hit ? s2_tile_1 : '0;
      out_tile_2_q <= s2_hit ? s2_tile_2 : '0;
    end else begin
      out_valid_q  <= 1'b0;
      out_miss_q   <= 1'b0;
    end
  end

  assign rd.input_valid_o  = out_valid_q;
  assign rd.miss_o         = out_miss_q;
  assign rd.input_data_o_1 = out_tile_1_q;
  assign rd.input_data_o_2 = out_tile_2_q;

endmodule

// File: tb/tb_input_tile_server.sv
// Directed self-checking bench for input_tile_server (TILE_DEPTH = 64).
module tb_input_tile_server;
  import wino_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_en_i = 1'b0;
  logic [7:0] wr_tile_addr_i = '0;
  logic [2:0] wr_row_i = '0;
  row_t       wr_data_i = '0;
  logic       clear_i = 1'b0;
  logic [8:0] tiles_loaded_o;

  int checks = 0;
  int errors = 0;

  input_tile_server_if rd_if ();

  input_tile_server #(.TILE_DEPTH(64)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .wr_en_i        (wr_en_i),
    .wr_tile_addr_i (wr_tile_addr_i),
    .wr_row_i       (wr_row_i),
    .wr_data_i      (wr_data_i),
    .clear_i        (clear_i),
    .rd             (rd_if),
    .tiles_loaded_o (tiles_loaded_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic row_t make_row(input int t, input int r);
    row_t m;
    for (int c = 0; c < 6; c++) m[c] = 16'(t*100 + r*6 + c);
    return m;
  endfunction

  function automatic tile_t make_tile(input int t);
    tile_t m;
    for (int r = 0; r < 6; r++) m[r] = make_row(t, r);
    return m;
  endfunction

  task automatic load_rows(input int t, input int r0, input int r1);
    for (int r = r0; r <= r1; r++) begin
      @(negedge clk);
      wr_en_i = 1'b1; wr_tile_addr_i = 8'(t); wr_row_i = 3'(r); wr_data_i = make_row(t, r);
    end
    @(negedge clk);
    wr_en_i = 1'b0;
  endtask

  // Returns at the negedge right after the sampling edge
  task automatic issue(input int a1, input int a2);
    @(negedge clk);
    rd_if.input_request_i = 1'b1; rd_if.input_addr_i_1 = 8'(a1); rd_if.input_addr_i_2 = 8'(a2);
    @(negedge clk);
    rd_if.input_request_i = 1'b0;
  endtask

  task automatic test_reset();
    rd_if.input_request_i = 1'b0; rd_if.input_addr_i_1 = '0; rd_if.input_addr_i_2 = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (rd_if.input_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", rd_if.input_valid_o); end
    checks++; if (rd_if.miss_o !== 1'b0) begin errors++; $display("FAIL rst_miss: got %b expected 0", rd_if.miss_o); end
    checks++; if (tiles_loaded_o !== 9'd0) begin errors++; $display("FAIL rst_loaded: got %0d expected 0", tiles_loaded_o); end
    checks++; if (rd_if.input_data_o_1 !== tile_t'('0)) begin errors++; $display("FAIL rst_data1: got %h expected 0", rd_if.input_data_o_1); end
    reset_n = 1'b1;
  endtask

  task automatic test_load_hit();
    tile_t e0, e1;
    e0 = make_tile(0); e1 = make_tile(1);
    for (int t = 0; t < 4; t++) load_rows(t, 0, 5);
    checks++; if (tiles_loaded_o !== 9'd4) begin errors++; $display("FAIL hit_loaded: got %0d expected 4", tiles_loaded_o); end
    issue(0, 1);
    @(negedge clk);
    checks++; if (rd_if.input_valid_o !== 1'b0) begin errors++; $display("FAIL hit_latency: got valid %b expected 0", rd_if.input_valid_o); end
    @(negedge clk);
    checks++; if (rd_if.input_valid_o !== 1'b1) begin errors++; $display("FAIL hit_valid: got %b expected 1", rd_if.input_valid_o); end
    checks++; if (rd_if.miss_o !== 1'b0) begin errors++; $display("FAIL hit_miss: got %b expected 0", rd_if.miss_o); end
    checks++; if (rd_if.input_data_o_1[2][3] !== 16'sd15) begin errors++; $display("FAIL hit_d1_23: got %0d expected 15", rd_if.input_data_o_1[2][3]); end
    checks++; if (rd_if.input_data_o_2[0][0] !== 16'sd100) begin errors++; $display("FAIL hit_d2_00: got %0d expected 100", rd_if.input_data_o_2[0][0]); end
    checks++; if (rd_if.input_data_o_1 !== e0) begin errors++; $display("FAIL hit_d1: got %h expected %h", rd_if.input_data_o_1, e0); end
    checks++; if (rd_if.input_data_o_2 !== e1) begin errors++; $display("FAIL hit_d2: got %h expected %h", rd_if.input_data_o_2, e1); end
  endtask

  task automatic test_miss_unloaded();
    issue(2, 9);
    repeat (2) @(negedge clk);
    checks++; if (rd_if.input_valid_o !== 1'b0) begin errors++; $display("FAIL miss_valid: got %b expected 0", rd_if.input_valid_o); end
    checks++; if (rd_if.miss_o !== 1'b1) begin errors++; $display("FAIL miss_pulse: got %b expected 1", rd_if.miss_o); end
    checks++; if (rd_if.input_data_o_1 !== tile_t'('0)) begin errors++; $display("FAIL miss_d1: got %h expected 0", rd_if.input_data_o_1); end
    checks++; if (rd_if.input_data_o_2 !== tile_t'('0)) begin errors++; $display("FAIL miss_d2: got %h expected 0", rd_if.input_data_o_2); end
    @(negedge clk);
    checks++; if (rd_if.miss_o !== 1'b0) begin errors++; $display("FAIL miss_one_cycle: got %b expected 0", rd_if.miss_o); end
  endtask

  task automatic test_out_of_range();
    issue(70, 0);
    repeat (2) @(negedge clk);
    checks++; if (rd_if.miss_o !== 1'b1) begin errors++; $display("FAIL oor_miss: got %b expected 1", rd_if.miss_o); end
    checks++; if (rd_if.input_valid_o !== 1'b0) begin errors++; $display("FAIL oor_valid: got %b expected 0", rd_if.input_valid_o); end
    load_rows(70, 5, 5);
    load_rows(3, 6, 6);
    checks++; if (tiles_loaded_o !== 9'd4) begin errors++; $display("FAIL oor_loaded: got %0d expected 4", tiles_loaded_o); end
  endtask

  task automatic test_back_to_back();
    tile_t e0, e1, e2, e3;
    e0 = make_tile(0); e1 = make_tile(1); e2 = make_tile(2); e3 = make_tile(3);
    @(negedge clk); rd_if.input_request_i = 1'b1; rd_if.input_addr_i_1 = 8'd0; rd_if.input_addr_i_2 = 8'd1;
    @(negedge clk); rd_if.input_addr_i_1 = 8'd2; rd_if.input_addr_i_2 = 8'd3;
    @(negedge clk); rd_if.input_addr_i_1 = 8'd0; rd_if.input_addr_i_2 = 8'd0;
    @(negedge clk); rd_if.input_request_i = 1'b0;
    checks++; if (rd_if.input_valid_o !== 1'b1 || rd_if.input_data_o_1 !== e0 || rd_if.input_data_o_2 !== e1) begin errors++; $display("FAIL b2b_r1: got v=%b %h expected v=1 %h", rd_if.input_valid_o, rd_if.input_data_o_1, e0); end
    @(negedge clk);
    checks++; if (rd_if.input_valid_o !== 1'b1 || rd_if.input_data_o_1 !== e2 || rd_if.input_data_o_2 !== e3) begin errors++; $display("FAIL b2b_r2: got v=%b %h expected v=1 %h", rd_if.input_valid_o, rd_if.input_data_o_1, e2); end
    @(negedge clk);
    checks++; if (rd_if.input_valid_o !== 1'b1 || rd_if.input_data_o_1 !== e0 || rd_if.input_data_o_2 !== e0) begin errors++; $display("FAIL b2b_r3: got v=%b %h expected v=1 %h", rd_if.input_valid_o, rd_if.input_data_o_2, e0); end
    @(negedge clk);
    checks++; if (rd_if.input_valid_o !== 1'b0 || rd_if.miss_o !== 1'b0) begin errors++; $display("FAIL idle_flags: got v=%b m=%b expected v=0 m=0", rd_if.input_valid_o, rd_if.miss_o); end
    checks++; if (rd_if.input_data_o_1 !== e0) begin errors++; $display("FAIL idle_hold: got %h expected %h", rd_if.input_data_o_1, e0); end
  endtask

  task automatic test_reload();
    load_rows(3, 0, 0);
    checks++; if (tiles_loaded_o !== 9'd3) begin errors++; $display("FAIL reload_dec: got %0d expected 3", tiles_loaded_o); end
    issue(3, 0);
    repeat (2) @(negedge clk);
    checks++; if (rd_if.miss_o !== 1'b1) begin errors++; $display("FAIL reload_miss: got %b expected 1", rd_if.miss_o); end
    load_rows(3, 1, 5);
    checks++; if (tiles_loaded_o !== 9'd4) begin errors++; $display("FAIL reload_inc: got %0d expected 4", tiles_loaded_o); end
  endtask

  task automatic test_wr_fwd();
    tile_t e5;
    e5 = make_tile(5);
    load_rows(5, 0, 4);
    checks++; if (tiles_loaded_o !== 9'd4) begin errors++; $display("FAIL fwd_pre_loaded: got %0d expected 4", tiles_loaded_o); end
    @(negedge clk);
    wr_en_i = 1'b1; wr_tile_addr_i = 8'd5; wr_row_i = 3'd5; wr_data_i = make_row(5, 5);
    rd_if.input_request_i = 1'b1; rd_if.input_addr_i_1 = 8'd5; rd_if.input_addr_i_2 = 8'd5;
    @(negedge clk);
    wr_en_i = 1'b0; rd_if.input_request_i = 1'b0;
    checks++; if (tiles_loaded_o !== 9'd5) begin errors++; $display("FAIL fwd_loaded: got %0d expected 5", tiles_loaded_o); end
    repeat (2) @(negedge clk);
`ifdef INPUT_TILE_SERVER_WR_FWD_EN
    checks++; if (rd_if.input_valid_o !== 1'b1 || rd_if.miss_o !== 1'b0) begin errors++; $display("FAIL fwd_same_cycle: got v=%b m=%b expected v=1 m=0", rd_if.input_valid_o, rd_if.miss_o); end
    checks++; if (rd_if.input_data_o_1 !== e5 || rd_if.input_data_o_2 !== e5) begin errors++; $display("FAIL fwd_data: got %h expected %h", rd_if.input_data_o_1, e5); end
`else
    checks++; if (rd_if.input_valid_o !== 1'b0 || rd_if.miss_o !== 1'b1) begin errors++; $display("FAIL nofwd_same_cycle: got v=%b m=%b expected v=0 m=1", rd_if.input_valid_o, rd_if.miss_o); end
`endif
    issue(5, 5);
    repeat (2) @(negedge clk);
    checks++; if (rd_if.input_valid_o !== 1'b1 || rd_if.input_data_o_2 !== e5) begin errors++; $display("FAIL fwd_after: got v=%b %h expected v=1 %h", rd_if.input_valid_o, rd_if.input_data_o_2, e5); end
  endtask

  task automatic test_clear_reset();
    tile_t e0, e1;
    e0 = make_tile(0); e1 = make_tile(1);
    @(negedge clk); rd_if.input_request_i = 1'b1; rd_if.input_addr_i_1 = 8'd0; rd_if.input_addr_i_2 = 8'd1;
    @(negedge clk); rd_if.input_request_i = 1'b0; clear_i = 1'b1;
    wr_en_i = 1'b1; wr_tile_addr_i = 8'd6; wr_row_i = 3'd5; wr_data_i = make_row(6, 5);
    @(negedge clk); clear_i = 1'b0; wr_en_i = 1'b0;
    checks++; if (tiles_loaded_o !== 9'd0) begin errors++; $display("FAIL clr_loaded: got %0d expected 0", tiles_loaded_o); end
    @(negedge clk);
    checks++; if (rd_if.input_valid_o !== 1'b1 || rd_if.input_data_o_1 !== e0 || rd_if.input_data_o_2 !== e1) begin errors++; $display("FAIL clr_inflight: got v=%b %h expected v=1 %h", rd_if.input_valid_o, rd_if.input_data_o_1, e0); end
    issue(0, 1);
    repeat (2) @(negedge clk);
    checks++; if (rd_if.miss_o !== 1'b1 || rd_if.input_valid_o !== 1'b0) begin errors++; $display("FAIL clr_next_miss: got v=%b m=%b expected v=0 m=1", rd_if.input_valid_o, rd_if.miss_o); end
    issue(6, 6);
    repeat (2) @(negedge clk);
    checks++; if (rd_if.miss_o !== 1'b1) begin errors++; $display("FAIL clr_prio: got m=%b expected 1", rd_if.miss_o); end
    // Reload tile 0 so outputs hold nonzero data and the in-flight request would hit
    load_rows(0, 0, 5);
    issue(0, 0);
    repeat (2) @(negedge clk);
    checks++; if (rd_if.input_valid_o !== 1'b1 || rd_if.input_data_o_1 !== e0) begin errors++; $display("FAIL rst_pre_hit: got v=%b expected v=1", rd_if.input_valid_o); end
    issue(0, 0);
    reset_n = 1'b0;
    #1;
    checks++; if (rd_if.input_valid_o !== 1'b0 || rd_if.miss_o !== 1'b0) begin errors++; $display("FAIL mid_rst_flags: got v=%b m=%b expected v=0 m=0", rd_if.input_valid_o, rd_if.miss_o); end
    checks++; if (rd_if.input_data_o_1 !== tile_t'('0) || rd_if.input_data_o_2 !== tile_t'('0)) begin errors++; $display("FAIL mid_rst_data: got %h expected 0", rd_if.input_data_o_1); end
    checks++; if (tiles_loaded_o !== 9'd0) begin errors++; $display("FAIL mid_rst_loaded: got %0d expected 0", tiles_loaded_o); end
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (rd_if.input_valid_o !== 1'b0 || rd_if.miss_o !== 1'b0) begin errors++; $display("FAIL post_rst_quiet%0d: got v=%b m=%b expected v=0 m=0", i, rd_if.input_valid_o, rd_if.miss_o); end
    end
  endtask

  initial begin
    test_reset();
    test_load_hit();
    test_miss_unloaded();
    test_out_of_range();
    test_back_to_back();
    test_reload();
    test_wr_fwd();
    test_clear_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
